// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains bytes from the upstream ring buffer and transmits each one on a
// UART line as 8N1 (one start bit, WordSize data bits LSB first, one stop bit).
// A refused read (buffer empty, or a write in the same cycle) is followed by a short
// backoff and an automatic retry.
//
// Ports:
//   clk            global clock
//   reset          asynchronous, active-high reset
//   txEnable       allows new reads; a frame already in progress always completes
//   dataReadEnable one-cycle read request to the ring buffer
//   dataReadAck    read success from the buffer; only meaningful in the cycle after a request
//   dataRead       byte from the buffer; only meaningful in the cycle after a request
//   txd            UART serial output, idles high
//   busy           high from a successful read until the end of the stop bit
//   bytesSent      count of completed frames (wraps)
//   debug          {state[3:0], bitIndex[3:0], 8'h0, lastByte[7:0], refusedCount[7:0]}
module uart_tx_drain #(
    parameter int unsigned WordSize     = 8,
    parameter int unsigned ClocksPerBit = 434,
    parameter int unsigned CounterBits  = 16,
    parameter int unsigned RetryGap     = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                txEnable,
    output logic                dataReadEnable,
    input  logic                dataReadAck,
    input  logic [WordSize-1:0] dataRead,
    output logic                txd,
    output logic                busy,
    output logic [31:0]         bytesSent,
    output logic [31:0]         debug
);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] REQ     = 4'd1;
    localparam logic [3:0] WAIT    = 4'd2;
    localparam logic [3:0] BACKOFF = 4'd3;
    localparam logic [3:0] START   = 4'd4;
    localparam logic [3:0] DATA    = 4'd5;
    localparam logic [3:0] STOP    = 4'd6;

    localparam logic [CounterBits-1:0] LastCount = CounterBits'(ClocksPerBit - 1);
    localparam logic [CounterBits-1:0] LastGap   = CounterBits'(RetryGap - 1);
    localparam logic [3:0]             LastBit   = 4'(WordSize - 1);

    logic [3:0]             state, state_next;
    logic [CounterBits-1:0] count, count_next;
    logic [3:0]             bit_index, bit_index_next;
    logic [WordSize-1:0]    shift, shift_next;
    logic [7:0]             last_byte, last_byte_next;
    logic [7:0]             refused_count, refused_next;
    logic [31:0]            sent_next;
    logic                   txd_next;
    logic                   req_next;
    logic                   busy_next;

    always_comb begin
        state_next     = state;
        count_next     = count;
        bit_index_next = bit_index;
        shift_next     = shift;
        last_byte_next = last_byte;
        refused_next   = refused_count;
        sent_next      = bytesSent;
        txd_next       = txd;
        req_next       = 1'b0;
        busy_next      = busy;

        case (state)
            IDLE: begin
                if (txEnable) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                end
            end
            REQ: begin
                state_next = WAIT;
            end
            WAIT: begin
                // The buffer's registered response belongs to the request of the previous cycle.
                count_next = '0;
                if (dataReadAck) begin
                    shift_next     = dataRead;
                    last_byte_next = 8'(dataRead);
                    busy_next      = 1'b1;
                    txd_next       = 1'b0;
                    state_next     = START;
                end else begin
                    if (refused_count != 8'hFF) begin
                        refused_next = refused_count + 8'd1;
                    end
                    state_next = BACKOFF;
                end
            end
            BACKOFF: begin
                if (count == LastGap) begin
                    count_next = '0;
                    state_next = IDLE;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            START: begin
                if (count == LastCount) begin
                    count_next     = '0;
                    bit_index_next = 4'd0;
                    txd_next       = shift[0];
                    state_next     = DATA;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            DATA: begin
                if (count == LastCount) begin
                    count_next = '0;
                    if (bit_index == LastBit) begin
                        bit_index_next = 4'd0;
                        txd_next       = 1'b1;
                        state_next     = STOP;
                    end else begin
                        bit_index_next = bit_index + 4'd1;
                        shift_next     = {1'b0, shift[WordSize-1:1]};
                        // Next bit is the one about to land in shift[0].
                        txd_next       = shift[1];
                    end
                end else begin
                    count_next = count + 1'b1;
                end
            end
            STOP: begin
                if (count == LastCount) begin
                    count_next = '0;
                    sent_next  = bytesSent + 32'd1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    count_next = count + 1'b1;
                end
            end
            default: begin
                count_next = '0;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            bit_index      <= 4'd0;
            shift          <= '0;
            last_byte      <= 8'd0;
            refused_count  <= 8'd0;
            bytesSent      <= 32'd0;
            txd            <= 1'b1;
            dataReadEnable <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            bit_index      <= bit_index_next;
            shift          <= shift_next;
            last_byte      <= last_byte_next;
            refused_count  <= refused_next;
            bytesSent      <= sent_next;
            txd            <= txd_next;
            dataReadEnable <= req_next;
            busy           <= busy_next;
        end
    end

    assign debug = {state, bit_index, 8'h00, last_byte, refused_count};

endmodule

// File: tb/tb_uart_tx_drain.sv
`timescale 1ns/1ps
module tb_uart_tx_drain;

    localparam int unsigned WS  = 8;
    localparam int unsigned CPB = 4;
    localparam int unsigned GAP = 4;
    localparam longint      Never = 64'sd1 << 40;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          txEnable = 1'b0;
    logic          dataReadEnable;
    logic          dataReadAck = 1'b0;
    logic [WS-1:0] dataRead = '0;
    logic          txd;
    logic          busy;
    logic [31:0]   bytesSent;
    logic [31:0]   debug;

    always #5 clk = ~clk;

    uart_tx_drain #(
        .WordSize    (WS),
        .ClocksPerBit(CPB),
        .CounterBits (16),
        .RetryGap    (GAP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .txEnable      (txEnable),
        .dataReadEnable(dataReadEnable),
        .dataReadAck   (dataReadAck),
        .dataRead      (dataRead),
        .txd           (txd),
        .busy          (busy),
        .bytesSent     (bytesSent),
        .debug         (debug)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Cycle c is the interval after the c-th rising edge.
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Ring buffer stand-in: writes win over a same-cycle read; ack/data sticky between reads.
    logic [7:0] fifo[$];
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    int         coll_req = 0;
    int         coll_done = 0;
    logic [7:0] coll_data = 8'h00;

    always @(posedge clk) begin
        if (dataReadEnable && coll_req != coll_done) begin
            fifo.push_back(coll_data);
            coll_done   <= coll_done + 1;
            dataReadAck <= 1'b0;
        end else if (dataReadEnable && (wr_en || fifo.size() == 0)) begin
            dataReadAck <= 1'b0;
        end else if (dataReadEnable) begin
            dataReadAck <= 1'b1;
            dataRead    <= fifo.pop_front();
        end
        if (wr_en) fifo.push_back(wr_data);
    end

    // Reference model kept as timestamps: when the request happens, when the frame spans.
    longint      m_req = -100, m_fstart = -100, m_fend = -101, m_ready = 0;
    int unsigned m_sent = 0;
    logic [7:0]  m_ref = 8'd0, m_last = 8'd0;

    function automatic logic frame_level(input logic [7:0] b, input longint k);
        longint bitn;
        bitn = k / CPB;
        if (bitn == 0) return 1'b0;
        if (bitn <= WS) return b[int'(bitn) - 1];
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            m_req    <= -100;
            m_fstart <= -100;
            m_fend   <= -101;
            m_ready  <= cyc + 1;
            m_sent   <= 0;
            m_ref    <= 8'd0;
            m_last   <= 8'd0;
        end else begin
            logic in_frame;
            in_frame = (cyc >= m_fstart) && (cyc <= m_fend);
            check("txd", 32'(txd), 32'(in_frame ? frame_level(m_last, cyc - m_fstart) : 1'b1));
            check("dataReadEnable", 32'(dataReadEnable), 32'(cyc == m_req));
            check("busy", 32'(busy), 32'(in_frame));
            check("bytesSent", bytesSent, m_sent);
            check("debug_low", debug & 32'h00FF_FFFF, {8'h00, 8'h00, m_last, m_ref});

            if (cyc == m_fend) m_sent <= m_sent + 1;
            if (cyc == m_req + 1) begin
                if (dataReadAck) begin
                    m_fstart <= cyc + 1;
                    m_fend   <= cyc + longint'((WS + 2) * CPB);
                    m_ready  <= cyc + longint'((WS + 2) * CPB) + 1;
                    m_last   <= dataRead;
                end else begin
                    m_ref   <= (m_ref == 8'hFF) ? m_ref : m_ref + 8'd1;
                    m_ready <= cyc + 1 + GAP;
                end
            end
            if (cyc >= m_ready && txEnable) begin
                m_req   <= cyc + 1;
                m_ready <= Never;
            end
        end
    end

    // UART receiver sampling each bit at its centre.
    logic       rx_active = 1'b0;
    longint     rx_start = 0, last_req = -100;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    longint     rx_starts[$];
    int         n_pulses = 0;

    always @(negedge clk) begin
        if (reset) begin
            rx_active <= 1'b0;
        end else begin
            longint k;
            if (dataReadEnable) begin
                last_req <= cyc;
                n_pulses <= n_pulses + 1;
            end
            if (!rx_active && txd == 1'b0) begin
                rx_active <= 1'b1;
                rx_start  <= cyc;
                check("req_to_start", 32'(cyc - last_req), 32'd2);
            end else if (rx_active) begin
                k = cyc - rx_start;
                for (int b = 1; b <= int'(WS); b++) begin
                    if (k == longint'(b * CPB + CPB / 2)) rx_byte[b-1] <= txd;
                end
                if (k == longint'((WS + 1) * CPB + CPB / 2)) begin
                    check("stop_bit", 32'(txd), 32'd1);
                    rx_q.push_back(rx_byte);
                    rx_starts.push_back(rx_start);
                    rx_active <= 1'b0;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic wait_pulse(input string name);
        int i = 0;
        while (!dataReadEnable && i < 200) begin
            step(1);
            i++;
        end
        check(name, 32'(dataReadEnable), 32'd1);
    endtask

    task automatic wait_rx(input int n, input string name);
        int i = 0;
        while (rx_q.size() < n && i < 2000) begin
            step(1);
            i++;
        end
        check(name, 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_ref(input logic [7:0] n, input string name);
        int i = 0;
        while (m_ref != n && i < 200) begin
            step(1);
            i++;
        end
        check(name, 32'(m_ref), 32'(n));
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hXX;
    endfunction

    function automatic longint start_gap(input int i);
        if (i < rx_starts.size() && i > 0) return rx_starts[i] - rx_starts[i-1];
        return -1;
    endfunction

    initial begin
        int p0;
        // Reset values, then idle with txEnable low.
        step(3);
        check("rst_txd", 32'(txd), 32'd1);
        check("rst_dre", 32'(dataReadEnable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sent", bytesSent, 32'd0);
        check("rst_debug", debug, 32'd0);
        reset = 1'b0;
        step(20);
        check("idle_pulses", 32'(n_pulses), 32'd0);
        check("idle_txd", 32'(txd), 32'd1);

        // Single byte A5.
        push(8'hA5);
        txEnable = 1'b1;
        wait_pulse("a5_req");
        txEnable = 1'b0;
        step(45);
        check("a5_sent", bytesSent, 32'd1);
        check("a5_lastbyte", 32'(debug[15:8]), 32'hA5);
        check("a5_rx", 32'(rx_at(0)), 32'hA5);
        check("a5_model_sent", m_sent, 32'd1);

        // Empty buffer: a request every RetryGap+3 cycles, all refused.
        p0 = n_pulses;
        txEnable = 1'b1;
        step(30);
        txEnable = 1'b0;
        step(10);
        check("empty_pulses", 32'(n_pulses - p0), 32'd5);
        check("empty_refused", 32'(debug[7:0]), 32'd5);
        check("empty_model_ref", 32'(m_ref), 32'd5);
        check("empty_sent", bytesSent, 32'd1);

        // Three bytes back to back, then the fourth request is refused.
        push(8'h01);
        push(8'h02);
        push(8'h03);
        txEnable = 1'b1;
        wait_rx(4, "burst_rx_count");
        wait_ref(8'd6, "burst_fourth_refused");
        txEnable = 1'b0;
        step(10);
        check("burst_b1", 32'(rx_at(1)), 32'h01);
        check("burst_b2", 32'(rx_at(2)), 32'h02);
        check("burst_b3", 32'(rx_at(3)), 32'h03);
        check("burst_gap12", 32'(start_gap(2)), 32'd43);
        check("burst_gap23", 32'(start_gap(3)), 32'd43);
        check("burst_sent", bytesSent, 32'd4);

        // Write collides with the request: refused, retried, nothing lost or doubled.
        push(8'h10);
        push(8'h11);
        coll_data = 8'h12;
        coll_req  = coll_req + 1;
        txEnable  = 1'b1;
        wait_rx(7, "coll_rx_count");
        wait_ref(8'd8, "coll_final_refused");
        txEnable = 1'b0;
        step(10);
        check("coll_b0", 32'(rx_at(4)), 32'h10);
        check("coll_b1", 32'(rx_at(5)), 32'h11);
        check("coll_b2", 32'(rx_at(6)), 32'h12);
        check("coll_sent", bytesSent, 32'd7);
        check("coll_refused", 32'(debug[7:0]), 32'd8);

        // Reset during DATA bit 3 of 8'h20 (bit 3 is 0); next frame must carry 8'h21.
        push(8'h20);
        push(8'h21);
        txEnable = 1'b1;
        wait_pulse("rst_req");
        step(19);
        #1;
        check("bit3_before_reset", 32'(txd), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_txd", 32'(txd), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sent", bytesSent, 32'd0);
        check("midrst_debug", debug, 32'd0);
        step(2);
        reset = 1'b0;
        wait_rx(8, "after_rst_rx_count");
        wait_ref(8'd1, "after_rst_refused");
        txEnable = 1'b0;
        step(10);
        check("after_rst_byte", 32'(rx_at(7)), 32'h21);
        check("after_rst_sent", bytesSent, 32'd1);
        check("after_rst_lastbyte", 32'(debug[15:8]), 32'h21);
        check("buffer_drained", 32'(fifo.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
